// File: rtl/clap_sequencer.sv
// Clap detector/sequencer: threshold with hysteresis, refractory holdoff, silence-closed sequences.
// Define CLAP_SEQ_ACCUM_EN to make countDisplay a running clap total instead of the last sequence length.
module clap_sequencer #(
  parameter logic [15:0] THRESH      = 16'h8000,
  parameter logic [15:0] RELEASE     = 16'h4000,
  parameter int          REFRACT_CYC = 1000,
  parameter int          WINDOW_CYC  = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] fftInDataAbs,
  input  logic        fftValid,
  output logic        clapPulse,
  output logic        seqDone,
  output logic [3:0]  seqCount,
  output logic        busy,
  output logic [3:0]  countDisplay
);

  localparam int MAX_CYC = (REFRACT_CYC > WINDOW_CYC) ? REFRACT_CYC : WINDOW_CYC;
  localparam int TW      = $clog2(MAX_CYC + 1);
  localparam logic [TW-1:0] REFRACT_LOAD = TW'(REFRACT_CYC - 1);
  localparam logic [TW-1:0] WINDOW_LOAD  = TW'(WINDOW_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HIGH    = 3'd1,
    S_REFRACT = 3'd2,
    S_GAP     = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    count_q, count_d;
  logic [3:0]    seq_count_q, seq_count_d;
  logic [3:0]    disp_q, disp_d;
  logic          armed_q, armed_d;
  logic          clap_q, clap_d;
  logic          done_q, done_d;
  logic          hit, quiet;

  assign hit   = fftValid && (fftInDataAbs >= THRESH);
  assign quiet = fftValid && (fftInDataAbs < RELEASE);

  always_comb begin
    state_d     = state_q;
    timer_d     = (timer_q == '0) ? '0 : timer_q - TW'(1);
    count_d     = count_q;
    seq_count_d = seq_count_q;
    disp_d      = disp_q;
    // armed drops only on a stuck-high timeout and returns with the next quiet sample
    armed_d     = armed_q | quiet;
    clap_d      = 1'b0;
    done_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (hit && armed_q) begin
          state_d = S_HIGH;
          count_d = 4'd1;
          clap_d  = 1'b1;
          timer_d = WINDOW_LOAD;
        end
      end
      S_HIGH: begin
        if (quiet) begin
          state_d = S_REFRACT;
          timer_d = REFRACT_LOAD;
        end else if (timer_q == '0) begin
          state_d = S_DONE;
          armed_d = 1'b0;
        end
      end
      S_REFRACT: begin
        if (timer_q == '0) begin
          state_d = S_GAP;
          timer_d = WINDOW_LOAD;
        end
      end
      S_GAP: begin
        if (hit) begin
          state_d = S_HIGH;
          clap_d  = 1'b1;
          count_d = (count_q == 4'd15) ? 4'd15 : count_q + 4'd1;
          timer_d = WINDOW_LOAD;
        end else if (timer_q == '0) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d     = S_IDLE;
        done_d      = 1'b1;
        seq_count_d = count_q;
        count_d     = 4'd0;
      end
      default: state_d = S_IDLE;
    endcase
`ifdef CLAP_SEQ_ACCUM_EN
    if (clap_d) disp_d = disp_q + 4'd1;
`else
    if (done_d) disp_d = count_q;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      count_q     <= 4'd0;
      seq_count_q <= 4'd0;
      disp_q      <= 4'd0;
      armed_q     <= 1'b1;
      clap_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      count_q     <= count_d;
      seq_count_q <= seq_count_d;
      disp_q      <= disp_d;
      armed_q     <= armed_d;
      clap_q      <= clap_d;
      done_q      <= done_d;
    end
  end

  assign clapPulse    = clap_q;
  assign seqDone      = done_q;
  assign seqCount     = seq_count_q;
  assign busy         = (state_q != S_IDLE);
  assign countDisplay = disp_q;

endmodule
